// File: rtl/scarv_cop_mem_rsp_pkg.sv
// rtl/scarv_cop_mem_rsp_pkg.sv - shared state encodings and constants for the coprocessor memory responder
package scarv_cop_mem_rsp_pkg;

    localparam int COUNT_W   = 4;
    localparam int WAIT_MAX  = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/scarv_cop_mem_rsp_ram.sv
// rtl/scarv_cop_mem_rsp_ram.sv - word-organised RAM, byte-enabled write port, asynchronous read port
//
// Ports:
//   i_clk    clock for the write port
//   i_wen    write strobe for this cycle's edge
//   i_waddr  word index written
//   i_wdata  lane-positioned write data
//   i_ben    per-byte write enables
//   i_raddr  word index read
//   o_rdata  combinational read data
module scarv_cop_mem_rsp_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_wen,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [3:0]    i_ben,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (i_ben[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/scarv_cop_mem_rsp.sv
// rtl/scarv_cop_mem_rsp.sv - slave responder for the coprocessor load/store bus with wait states and fault injection
//
// Ports:
//   g_clk, g_resetn    clock and synchronous active-low reset
//   cop_mem_cen/wen    request valid and direction (1 = write)
//   cop_mem_addr       word-aligned byte address
//   cop_mem_wdata/ben  lane-positioned write data and byte enables
//   cop_mem_rdata      read data, non-zero only in the response cycle
//   cop_mem_stall      high while the response is pending
//   cop_mem_error      bus error, only in the response cycle
//   inj_stall          extends the wait phase while high
//   inj_error          forces an error on the request accepted this cycle
module scarv_cop_mem_rsp
    import scarv_cop_mem_rsp_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        cop_mem_cen,
    input  logic        cop_mem_wen,
    input  logic [31:0] cop_mem_addr,
    input  logic [31:0] cop_mem_wdata,
    input  logic [3:0]  cop_mem_ben,
    output logic [31:0] cop_mem_rdata,
    output logic        cop_mem_stall,
    output logic        cop_mem_error,
    input  logic        inj_stall,
    input  logic        inj_error
);

    localparam int                 AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0]        SPAN      = 33'(4 * DEPTH_WORDS);
    localparam logic [32:0]        BASE33    = {1'b0, BASE_ADDR};
    localparam logic [COUNT_W-1:0] WAIT_INIT = COUNT_W'(WAIT_CYCLES);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] w_count_nxt;

    logic [AW-1:0]      r_idx;
    logic               r_wen;
    logic [31:0]        r_wdata;
    logic [3:0]         r_ben;
    logic               r_err;

    logic               w_accept;
    logic [32:0]        w_off33;
    logic               w_oor;
    logic [AW-1:0]      w_idx;
    logic               w_ram_we;
    logic [31:0]        w_ram_rdata;

    // A 33-bit offset makes addresses below BASE_ADDR wrap to >= 2^32,
    // so a single compare against the span covers both bounds.
    assign w_off33  = {1'b0, cop_mem_addr} - BASE33;
    assign w_oor    = (w_off33 >= SPAN);
    assign w_idx    = AW'(w_off33 >> 2);

    assign w_accept = cop_mem_cen && ((r_state == ST_IDLE) || (r_state == ST_RESP));

    // Gating on g_resetn keeps a reset that lands in RESP from committing the write.
    assign w_ram_we = (r_state == ST_RESP) && r_wen && !r_err && g_resetn;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_idx   <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_ben   <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= w_idx;
            r_wen   <= cop_mem_wen;
            r_wdata <= cop_mem_wdata;
            r_ben   <= cop_mem_ben;
            r_err   <= inj_error || (cop_mem_addr[1:0] != 2'b00) || w_oor;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        cop_mem_stall = 1'b0;
        cop_mem_error = 1'b0;
        cop_mem_rdata = '0;

        case (r_state)
            ST_WAIT: begin
                cop_mem_stall = 1'b1;
                w_count_nxt   = (r_count == '0) ? '0 : r_count - 1'b1;
                if ((r_count <= COUNT_W'(1)) && !inj_stall) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                cop_mem_error = r_err;
                if (!r_wen && !r_err) begin
                    cop_mem_rdata = w_ram_rdata;
                end
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Acceptance from IDLE and back-to-back acceptance from RESP share one path.
        if (w_accept) begin
            if ((WAIT_CYCLES == 0) && !inj_stall) begin
                w_state_nxt = ST_RESP;
            end else begin
                w_state_nxt = ST_WAIT;
                w_count_nxt = WAIT_INIT;
            end
        end
    end

    scarv_cop_mem_rsp_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .i_clk   (g_clk),
        .i_wen   (w_ram_we),
        .i_waddr (r_idx),
        .i_wdata (r_wdata),
        .i_ben   (r_ben),
        .i_raddr (r_idx),
        .o_rdata (w_ram_rdata)
    );

endmodule

// File: tb/tb_scarv_cop_mem_rsp.sv
// tb/tb_scarv_cop_mem_rsp.sv - directed self-checking bench for scarv_cop_mem_rsp (zero-wait and three-wait instances)
module tb_scarv_cop_mem_rsp;

    logic        clk = 1'b0;
    logic        resetn [2];
    logic        cen    [2];
    logic        wen    [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic [3:0]  ben    [2];
    logic        istall [2];
    logic        ierr   [2];
    logic [31:0] rdata  [2];
    logic        stall  [2];
    logic        error  [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    scarv_cop_mem_rsp #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut0 (
        .g_clk(clk), .g_resetn(resetn[0]), .cop_mem_cen(cen[0]), .cop_mem_wen(wen[0]),
        .cop_mem_addr(addr[0]), .cop_mem_wdata(wdata[0]), .cop_mem_ben(ben[0]),
        .cop_mem_rdata(rdata[0]), .cop_mem_stall(stall[0]), .cop_mem_error(error[0]),
        .inj_stall(istall[0]), .inj_error(ierr[0])
    );

    scarv_cop_mem_rsp #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) dut3 (
        .g_clk(clk), .g_resetn(resetn[1]), .cop_mem_cen(cen[1]), .cop_mem_wen(wen[1]),
        .cop_mem_addr(addr[1]), .cop_mem_wdata(wdata[1]), .cop_mem_ben(ben[1]),
        .cop_mem_rdata(rdata[1]), .cop_mem_stall(stall[1]), .cop_mem_error(error[1]),
        .inj_stall(istall[1]), .inj_error(ierr[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input int d, input logic w, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] be, input logic ie);
        cen[d]   = 1'b1;
        wen[d]   = w;
        addr[d]  = a;
        wdata[d] = wd;
        ben[d]   = be;
        ierr[d]  = ie;
    endtask

    // Advances until the first cycle with stall low; leaves cen untouched.
    task automatic wait_resp(input int d, output logic [31:0] rd, output logic er, output int ns);
        logic done;
        done = 1'b0;
        ns   = 0;
        rd   = 'x;
        er   = 1'bx;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
            ierr[d] = 1'b0;
            if (!stall[d]) begin
                rd   = rdata[d];
                er   = error[d];
                done = 1'b1;
            end else begin
                ns++;
            end
        end
        check("resp_seen", {31'b0, done}, 32'd1);
    endtask

    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic ie,
                       output logic [31:0] rd, output logic er, output int ns);
        @(posedge clk); #1;
        start_req(d, w, a, wd, be, ie);
        wait_resp(d, rd, er, ns);
        cen[d] = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          ns;
    int          tot;

    initial begin
        for (int d = 0; d < 2; d++) begin
            resetn[d] = 1'b0; cen[d] = 1'b0; wen[d] = 1'b0; addr[d] = '0;
            wdata[d] = '0; ben[d] = '0; istall[d] = 1'b0; ierr[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_stall", {31'b0, stall[d]}, 32'd0);
            check("rst_error", {31'b0, error[d]}, 32'd0);
            check("rst_rdata", rdata[d], 32'd0);
        end
        resetn[0] = 1'b1; resetn[1] = 1'b1;

        // Zero-wait write then read
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd, er, ns);
        check("w0_stalls", ns, 0);
        check("w0_error", {31'b0, er}, 0);
        check("w0_rdata", rd, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, ns);
        check("r0_stalls", ns, 0);
        check("r0_rdata", rd, 32'hDEADBEEF);
        check("r0_error", {31'b0, er}, 0);

        // Byte lane write
        txn(0, 1'b1, 32'h04, 32'h11223344, 4'hF, 1'b0, rd, er, ns);
        txn(0, 1'b1, 32'h04, 32'hAA000000, 4'b1000, 1'b0, rd, er, ns);
        txn(0, 1'b0, 32'h04, 32'h0, 4'h0, 1'b0, rd, er, ns);
        check("lane_rdata", rd, 32'hAA223344);

        // Out-of-range write must not alias onto word 0 or touch the last word
        txn(0, 1'b1, 32'hFC, 32'hCAFEF00D, 4'hF, 1'b0, rd, er, ns);
        txn(0, 1'b1, 32'h00, 32'h0BADC0DE, 4'hF, 1'b0, rd, er, ns);
        txn(0, 1'b1, 32'h100, 32'h55, 4'hF, 1'b0, rd, er, ns);
        check("oor_error", {31'b0, er}, 1);
        check("oor_rdata", rd, 0);
        txn(0, 1'b0, 32'hFC, 32'h0, 4'h0, 1'b0, rd, er, ns);
        check("oor_last", rd, 32'hCAFEF00D);
        txn(0, 1'b0, 32'h00, 32'h0, 4'h0, 1'b0, rd, er, ns);
        check("oor_word0", rd, 32'h0BADC0DE);

        // Misaligned read
        txn(0, 1'b0, 32'h12, 32'h0, 4'h0, 1'b0, rd, er, ns);
        check("mis_error", {31'b0, er}, 1);
        check("mis_rdata", rd, 0);

        // inj_stall high for the accept cycle plus four more
        @(posedge clk); #1;
        start_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        istall[0] = 1'b1;
        tot = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (stall[0]) tot++;
        end
        istall[0] = 1'b0;
        wait_resp(0, rd, er, ns);
        cen[0] = 1'b0;
        check("istall_cycles", tot + ns, 5);
        check("istall_rdata", rd, 32'hDEADBEEF);

        // inj_error on a write blocks the commit
        txn(0, 1'b1, 32'h10, 32'h0, 4'hF, 1'b1, rd, er, ns);
        check("ierr_error", {31'b0, er}, 1);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, ns);
        check("ierr_nocommit", rd, 32'hDEADBEEF);
        check("ierr_cleared", {31'b0, er}, 0);

        // ben=0 is a no-op write
        txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b0, rd, er, ns);
        check("ben0_error", {31'b0, er}, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, ns);
        check("ben0_rdata", rd, 32'hDEADBEEF);

        // Back-to-back read in the write's RESP cycle
        @(posedge clk); #1;
        start_req(0, 1'b1, 32'h30, 32'h600DF00D, 4'hF, 1'b0);
        wait_resp(0, rd, er, ns);
        start_req(0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0);
        wait_resp(0, rd, er, ns);
        cen[0] = 1'b0;
        check("b2b_stalls", ns, 0);
        check("b2b_rdata", rd, 32'h600DF00D);

        // Reset landing in a write's RESP cycle
        txn(0, 1'b1, 32'h34, 32'h00000001, 4'hF, 1'b0, rd, er, ns);
        @(posedge clk); #1;
        start_req(0, 1'b1, 32'h34, 32'h77777777, 4'hF, 1'b0);
        wait_resp(0, rd, er, ns);
        resetn[0] = 1'b0;
        cen[0]    = 1'b0;
        @(posedge clk); #1;
        check("rresp_stall", {31'b0, stall[0]}, 0);
        check("rresp_error", {31'b0, error[0]}, 0);
        resetn[0] = 1'b1;
        txn(0, 1'b0, 32'h34, 32'h0, 4'h0, 1'b0, rd, er, ns);
        check("rresp_nocommit", rd, 32'h00000001);

        // Three wait states
        txn(1, 1'b1, 32'h20, 32'h87654321, 4'hF, 1'b0, rd, er, ns);
        check("w3_stalls", ns, 3);
        txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd, er, ns);
        check("r3_stalls", ns, 3);
        check("r3_rdata", rd, 32'h87654321);
        check("r3_error", {31'b0, er}, 0);

        // Reset landing in WAIT of a write
        txn(1, 1'b1, 32'h24, 32'h00001234, 4'hF, 1'b0, rd, er, ns);
        @(posedge clk); #1;
        start_req(1, 1'b1, 32'h24, 32'h00009999, 4'hF, 1'b0);
        @(posedge clk); #1;
        check("rwait_in_wait", {31'b0, stall[1]}, 1);
        resetn[1] = 1'b0;
        cen[1]    = 1'b0;
        @(posedge clk); #1;
        check("rwait_stall", {31'b0, stall[1]}, 0);
        resetn[1] = 1'b1;
        repeat (4) @(posedge clk);
        txn(1, 1'b0, 32'h24, 32'h0, 4'h0, 1'b0, rd, er, ns);
        check("rwait_nocommit", rd, 32'h00001234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scarv_cop_mem_rsp.md
Name: scarv_cop_mem_rsp

Overview:
- Memory responder for the coprocessor load/store bus (cop_mem_*). It is the slave end of the interface the coprocessor memory unit initiates on.
- Provides a byte-enabled, word-organised memory with a configurable number of wait states, address-range checking and bench-controlled stall/error injection.
- Used as the memory behind the coprocessor in unit/integration benches and in FPGA smoke-test builds.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to 4*DEPTH_WORDS.
- WAIT_CYCLES, 0: minimum stall cycles per transaction, range 0..15.

Ports:
- g_clk  in  1  global clock
- g_resetn  in  1  synchronous active-low reset
- cop_mem_cen  in  1  request valid / chip enable
- cop_mem_wen  in  1  1 = write, 0 = read
- cop_mem_addr  in  32  byte address; word aligned by the initiator
- cop_mem_wdata  in  32  write data, already lane-positioned
- cop_mem_ben  in  4  write byte enables; ignored for reads
- cop_mem_rdata  out  32  read data; valid only in the RESP cycle
- cop_mem_stall  out  1  response not yet ready
- cop_mem_error  out  1  bus error; valid only in the RESP cycle
- inj_stall  in  1  bench: extend the current WAIT
- inj_error  in  1  bench: force error on the request accepted this cycle

Behaviour:
- Clock and reset: one clock, g_clk. Reset is synchronous and active-low on g_resetn.
- Reset values: state=IDLE, cop_mem_stall=0, cop_mem_error=0, cop_mem_rdata=0, count=0. Memory contents are not reset.
- Protocol: the request is presented in cycle N with cen=1. The response is seen in the first cycle after N in which stall=0; that cycle is the RESP state. The initiator holds cen high while stall=1 and drops it in the RESP cycle.
- Acceptance: in IDLE or RESP with cen=1, latch addr, wen, wdata, ben and the error flag. Inputs during WAIT are ignored.
- Error flag = inj_error OR addr[1:0]!=0 OR addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS). Range arithmetic is 33-bit so the top bound cannot wrap.
- States: IDLE, WAIT, RESP. Encoding is in the package.
- IDLE: cen=1 and WAIT_CYCLES==0 and inj_stall=0 -> RESP. cen=1 otherwise -> WAIT with count=WAIT_CYCLES. cen=0 -> IDLE.
- WAIT: stall=1; count decrements each cycle, saturating at 0. Exit -> RESP at the end of a cycle where count<=1 and inj_stall=0, otherwise stay.
  - With no injection, WAIT lasts exactly WAIT_CYCLES cycles.
  - With WAIT_CYCLES=0 and inj_stall high at accept, WAIT lasts until inj_stall falls.
- RESP:
  - stall=0; error=latched flag.
  - Read: rdata = mem[latched word index]. If error is set, rdata=0.
  - Write: rdata=0. The write commits at the clock edge ending RESP, only if the error flag is clear. Byte lane i is written iff ben[i]. ben=4'b0000 is a legal no-op.
  - Next state: cen=1 -> accept as from IDLE (back-to-back); else IDLE.
- Read-after-write: a read accepted in a write's RESP cycle returns the post-write data.
- Outside RESP: rdata=0 and error=0. Stall is 1 only in WAIT.
- Reset asserted mid-WAIT or mid-RESP: the pending transaction is discarded, no memory write occurs, and outputs return to reset values in the next cycle.
- Index = (addr-BASE_ADDR)[log2(4*DEPTH_WORDS)-1:2]. Upper address bits are not used for indexing.

Decomposition:
- Package scarv_cop_mem_rsp_pkg holds the state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), the WAIT_CYCLES maximum (15) and the 4-bit count width.
- Sub-module scarv_cop_mem_rsp_ram: DEPTH_WORDS x 32 array.
  - One write port with 4-bit byte enables.
  - One asynchronous read port indexed by the latched address.
- The FSM, latch registers and range check stay in the top level.

Test Plan:
- WAIT_CYCLES=0: write 32'hDEADBEEF to 0x10 with ben=4'hF, then read 0x10 -> stall never 1; rdata=32'hDEADBEEF one cycle after the read cen; error=0.
- WAIT_CYCLES=3: read 0x20 -> stall=1 for exactly 3 cycles, then the RESP cycle with rdata=mem[8].
- Byte lanes: mem[1]=32'h11223344; write 0x04 with wdata=32'hAA00_0000 and ben=4'b1000 -> a subsequent read returns 32'hAA223344.
- Out-of-range write to BASE_ADDR+4*DEPTH_WORDS with wdata=32'h55 -> error=1 in RESP, rdata=0, memory unchanged (probe the last word).
- Injection: inj_stall held for 5 cycles at accept with WAIT_CYCLES=0 -> 5 stall cycles, then RESP. inj_error on a write -> error=1 and no commit.
- Back-to-back and reset: write 0x30 and, in its RESP cycle, issue a read of 0x30 -> returns the new data. Reset pulse during WAIT of a write -> no commit, stall=0 next cycle.
